// File: rtl/isochronous_handshake_array.sv
// isochronous_handshake_array
//
// Purpose:
//   Multi-channel buffered ready/valid crossing between two rate domains that
//   share one physical clock and differ only by clock-enable strobes. Each
//   channel owns a small circular buffer. The write pointer lives in the source
//   domain and the read pointer lives in the destination domain. Each side sees
//   the other's pointer only through a copy that is refreshed on its own tick.
//
// Ports:
//   clk_i        shared clock, rising edge
//   rst_ni       synchronous active-low reset
//   src_en_i     source-domain tick; pushes happen only when high
//   dst_en_i     destination-domain tick; pops happen only when high
//   src_valid_i  per-channel push request
//   src_ready_o  per-channel "buffer not full" as seen by the source
//   src_data_i   per-channel payload, channel c at [c*DataWidth +: DataWidth]
//   dst_valid_o  per-channel "data available" as seen by the destination
//   dst_ready_i  per-channel pop request
//   dst_data_o   per-channel head entry (zero when PassData is 0)

module isochronous_handshake_array #(
    parameter int unsigned NumChannels = 4,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned Depth       = 2,
    parameter bit          PassData    = 1'b1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             src_en_i,
    input  logic                             dst_en_i,
    input  logic [NumChannels-1:0]           src_valid_i,
    output logic [NumChannels-1:0]           src_ready_o,
    input  logic [NumChannels*DataWidth-1:0] src_data_i,
    output logic [NumChannels-1:0]           dst_valid_o,
    input  logic [NumChannels-1:0]           dst_ready_i,
    output logic [NumChannels*DataWidth-1:0] dst_data_o
);

    // One extra pointer bit separates "full" from "empty".
    localparam int unsigned     PtrW   = $clog2(Depth) + 1;
    localparam logic [PtrW-1:0] DepthP = PtrW'(Depth);

    if (!(Depth == 1 || Depth == 2 || Depth == 4 || Depth == 8 || Depth == 16)) begin : gBadDepth
        $error("isochronous_handshake_array: Depth must be a power of two in 1..16");
    end
    if (NumChannels < 1 || DataWidth < 1) begin : gBadShape
        $error("isochronous_handshake_array: NumChannels and DataWidth must be at least 1");
    end

    for (genvar c = 0; c < NumChannels; c++) begin : gChan
        logic [PtrW-1:0]      r_wrPtr;
        logic [PtrW-1:0]      r_rdPtr;
        logic [PtrW-1:0]      r_wrPtrDst;
        logic [PtrW-1:0]      r_rdPtrSrc;
        logic                 w_ready;
        logic                 w_valid;
        logic                 w_push;
        logic                 w_pop;
        logic [DataWidth-1:0] w_srcData;
        logic [DataWidth-1:0] w_headData;

        assign w_srcData = src_data_i[c*DataWidth +: DataWidth];

        // Each side judges occupancy against a possibly stale copy of the far
        // pointer. The stale copy is always conservative: the source never
        // overruns an unread entry, and the destination never reads an entry
        // before its data has landed.
        assign w_ready = (r_wrPtr - r_rdPtrSrc) != DepthP;
        assign w_valid = r_wrPtrDst != r_rdPtr;
        assign w_push  = src_en_i & src_valid_i[c] & w_ready;
        assign w_pop   = dst_en_i & w_valid & dst_ready_i[c];

        // Each pointer advances only on its own tick. The cross copies are
        // refreshed on the tick of the domain that consumes them.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_wrPtr    <= '0;
                r_rdPtr    <= '0;
                r_wrPtrDst <= '0;
                r_rdPtrSrc <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PtrW'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PtrW'(1);
                end
                if (dst_en_i) begin
                    r_wrPtrDst <= r_wrPtr;
                end
                if (src_en_i) begin
                    r_rdPtrSrc <= r_rdPtr;
                end
            end
        end

        if (PassData) begin : gData
            localparam int unsigned IdxW = (PtrW > 1) ? PtrW - 1 : 1;
            logic [DataWidth-1:0] r_mem [Depth];
            logic [IdxW-1:0]      w_wrIdx;
            logic [IdxW-1:0]      w_rdIdx;

            if (Depth > 1) begin : gIdx
                assign w_wrIdx = r_wrPtr[PtrW-2:0];
                assign w_rdIdx = r_rdPtr[PtrW-2:0];
            end else begin : gIdxSingle
                assign w_wrIdx = '0;
                assign w_rdIdx = '0;
            end

            // The entry is written on the same edge that bumps r_wrPtr. The
            // destination only sees the new pointer one copy stage later, so
            // the data is already settled when valid rises.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int i = 0; i < Depth; i++) begin
                        r_mem[i] <= '0;
                    end
                end else if (w_push) begin
                    r_mem[w_wrIdx] <= w_srcData;
                end
            end

            assign w_headData = r_mem[w_rdIdx];
        end else begin : gNoData
            assign w_headData = '0;
        end

        assign src_ready_o[c]                         = w_ready;
        assign dst_valid_o[c]                         = w_valid;
        assign dst_data_o[c*DataWidth +: DataWidth]   = w_headData;

`ifndef SYNTHESIS
        logic                 r_srcArm;
        logic [DataWidth-1:0] r_srcHeld;
        logic                 r_dstArm;
        logic [DataWidth-1:0] r_dstHeld;

        // A request refused on one source tick must still be present, with
        // the same payload, on the next source tick.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_srcArm  <= 1'b0;
                r_srcHeld <= '0;
            end else if (src_en_i) begin
                if (r_srcArm) begin
                    srcHoldA: assert (src_valid_i[c] && (w_srcData == r_srcHeld));
                end
                r_srcArm  <= src_valid_i[c] & ~w_ready;
                r_srcHeld <= w_srcData;
            end
        end

        // An unconsumed head entry must not move or vanish.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_dstArm  <= 1'b0;
                r_dstHeld <= '0;
            end else begin
                if (r_dstArm) begin
                    dstHoldA: assert (w_valid && (w_headData == r_dstHeld));
                end
                r_dstArm  <= w_valid & ~w_pop;
                r_dstHeld <= w_headData;
            end
        end
`endif
    end

endmodule

// File: tb/tb_isochronous_handshake_array.sv
// tb_isochronous_handshake_array
//
// Self-checking bench with two instances that share one clock:
//   dutA: 4 channels, 32-bit payload, Depth 4, PassData on
//   dutB: 1 channel, 8-bit payload, Depth 1, PassData off
// A negedge monitor keeps one queue of expected words per channel. It pushes a
// word on every accepted source handshake and pops and compares on every
// destination handshake. Directed sequences check reset values, latency, the
// full and wrap behaviour, simultaneous push and pop, and reset discard.

module tb_isochronous_handshake_array;

    localparam int NCH   = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rstN;
    logic               srcEn;
    logic               dstEn;
    logic [NCH-1:0]     srcValid;
    logic [NCH-1:0]     srcReady;
    logic [NCH*DW-1:0]  srcData;
    logic [NCH-1:0]     dstValid;
    logic [NCH-1:0]     dstReady;
    logic [NCH*DW-1:0]  dstData;

    logic               bSrcValid;
    logic               bSrcReady;
    logic [7:0]         bSrcData;
    logic               bDstValid;
    logic               bDstReady;
    logic [7:0]         bDstData;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] expQ [NCH][$];
    int            pushCnt [NCH];
    int            popCnt  [NCH];
    int            bPushCnt;
    int            bPopCnt;
    logic [NCH-1:0] prevHold;
    logic [DW-1:0]  prevData [NCH];

    isochronous_handshake_array #(
        .NumChannels(NCH),
        .DataWidth  (DW),
        .Depth      (DEPTH),
        .PassData   (1'b1)
    ) dutA (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .src_en_i   (srcEn),
        .dst_en_i   (dstEn),
        .src_valid_i(srcValid),
        .src_ready_o(srcReady),
        .src_data_i (srcData),
        .dst_valid_o(dstValid),
        .dst_ready_i(dstReady),
        .dst_data_o (dstData)
    );

    isochronous_handshake_array #(
        .NumChannels(1),
        .DataWidth  (8),
        .Depth      (1),
        .PassData   (1'b0)
    ) dutB (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .src_en_i   (srcEn),
        .dst_en_i   (dstEn),
        .src_valid_i(bSrcValid),
        .src_ready_o(bSrcReady),
        .src_data_i (bSrcData),
        .dst_valid_o(bDstValid),
        .dst_ready_i(bDstReady),
        .dst_data_o (bDstData)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one source channel of dutA.
    task automatic applyStimulus(input int c, input logic v, input logic [DW-1:0] d);
        srcValid[c]         = v;
        srcData[c*DW +: DW] = d;
    endtask

    // Step to just after the next rising edge, where inputs are changed and
    // registered outputs have settled.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and stability monitor, sampled mid-cycle.
    initial begin
        for (int c = 0; c < NCH; c++) begin
            pushCnt[c]  = 0;
            popCnt[c]   = 0;
            prevData[c] = '0;
        end
        bPushCnt = 0;
        bPopCnt  = 0;
        prevHold = '0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                for (int c = 0; c < NCH; c++) expQ[c].delete();
                prevHold = '0;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (prevHold[c]) begin
                        checkOutput($sformatf("hold-valid ch%0d", c), 32'(dstValid[c]), 32'd1);
                        checkOutput($sformatf("hold-data ch%0d", c), dstData[c*DW +: DW], prevData[c]);
                    end
                    prevHold[c] = dstValid[c] && !(dstEn && dstReady[c]);
                    prevData[c] = dstData[c*DW +: DW];
                    if (srcEn && srcValid[c] && srcReady[c]) begin
                        expQ[c].push_back(srcData[c*DW +: DW]);
                        pushCnt[c]++;
                    end
                    if (dstEn && dstValid[c] && dstReady[c]) begin
                        if (expQ[c].size() == 0) begin
                            checkOutput($sformatf("pop-unexpected ch%0d", c), 32'd1, 32'd0);
                        end else begin
                            logic [DW-1:0] want;
                            want = expQ[c].pop_front();
                            checkOutput($sformatf("data ch%0d", c), dstData[c*DW +: DW], want);
                        end
                        popCnt[c]++;
                    end
                end
                if (srcEn && bSrcValid && bSrcReady) bPushCnt++;
                if (dstEn && bDstValid && bDstReady) begin
                    bPopCnt++;
                    checkOutput("b-data-zero", 32'(bDstData), 32'd0);
                end
            end
        end
    end

    initial begin
        int p0, q0, k, cyc;
        logic acc;
        logic [NCH-1:0] accV;
        int sent [NCH];
        int base [NCH];
        bit done;
        int bSent, bp0, bq0;

        // ---------------- reset with random inputs ----------------
        rstN = 1'b0;
        repeat (2) begin
            srcEn     = 1'($urandom);
            dstEn     = 1'($urandom);
            srcValid  = NCH'($urandom);
            dstReady  = NCH'($urandom);
            srcData   = {$urandom, $urandom, $urandom, $urandom};
            bSrcValid = 1'($urandom);
            bSrcData  = 8'($urandom);
            bDstReady = 1'($urandom);
            nextCycle();
        end
        checkOutput("rst-src-ready", 32'(srcReady), 32'hF);
        checkOutput("rst-dst-valid", 32'(dstValid), 32'h0);
        for (int c = 0; c < NCH; c++)
            checkOutput($sformatf("rst-dst-data ch%0d", c), dstData[c*DW +: DW], 32'h0);
        checkOutput("rst-b-ready", 32'(bSrcReady), 32'd1);
        checkOutput("rst-b-valid", 32'(bDstValid), 32'd0);

        srcEn = 1'b1; dstEn = 1'b1;
        srcValid = '0; dstReady = '0; srcData = '0;
        bSrcValid = 1'b0; bSrcData = 8'h00; bDstReady = 1'b0;
        rstN = 1'b1;
        nextCycle();

        // ---------------- latency (enables tied high) ----------------
        applyStimulus(0, 1'b1, 32'hA5A5_0001);
        bSrcValid = 1'b1;
        checkOutput("lat-a-ready-t0", 32'(srcReady[0]), 32'd1);
        checkOutput("lat-b-ready-t0", 32'(bSrcReady), 32'd1);
        nextCycle();
        applyStimulus(0, 1'b0, 32'h0);
        bSrcValid = 1'b0;
        checkOutput("lat-a-valid-t1", 32'(dstValid[0]), 32'd0);
        checkOutput("lat-b-valid-t1", 32'(bDstValid), 32'd0);
        checkOutput("lat-b-ready-t1", 32'(bSrcReady), 32'd0);
        nextCycle();
        checkOutput("lat-a-valid-t2", 32'(dstValid[0]), 32'd1);
        checkOutput("lat-a-data-t2", dstData[31:0], 32'hA5A5_0001);
        checkOutput("lat-b-valid-t2", 32'(bDstValid), 32'd1);
        checkOutput("lat-b-ready-t2", 32'(bSrcReady), 32'd0);
        dstReady[0] = 1'b1;
        bDstReady   = 1'b1;
        nextCycle();
        dstReady[0] = 1'b0;
        bDstReady   = 1'b0;
        checkOutput("lat-a-valid-t3", 32'(dstValid[0]), 32'd0);
        checkOutput("lat-b-valid-t3", 32'(bDstValid), 32'd0);
        checkOutput("lat-b-ready-t3", 32'(bSrcReady), 32'd0);
        nextCycle();
        checkOutput("lat-b-ready-t4", 32'(bSrcReady), 32'd1);
        nextCycle();

        // ---------------- full and wrap on ch2 ----------------
        p0 = pushCnt[2];
        q0 = popCnt[2];
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2, 1'b1, 32'h200 + 32'(i));
            checkOutput($sformatf("full-ready w%0d", i), 32'(srcReady[2]), 32'd1);
            nextCycle();
        end
        applyStimulus(2, 1'b1, 32'h204);
        checkOutput("full-ready-5th", 32'(srcReady[2]), 32'd0);
        repeat (3) nextCycle();
        checkOutput("full-accepted", 32'(pushCnt[2] - p0), 32'd4);
        checkOutput("full-ready-held", 32'(srcReady[2]), 32'd0);
        checkOutput("full-head-valid", 32'(dstValid[2]), 32'd1);
        checkOutput("full-head-data", dstData[2*DW +: DW], 32'h200);
        dstReady[2] = 1'b1;
        k = 4;
        cyc = 0;
        while ((popCnt[2] - q0) < 20 && cyc < 500) begin
            acc = srcEn && srcValid[2] && srcReady[2];
            nextCycle();
            cyc++;
            if (acc) begin
                k++;
                if (k < 20) applyStimulus(2, 1'b1, 32'h200 + 32'(k));
                else        applyStimulus(2, 1'b0, 32'h0);
            end
        end
        dstReady[2] = 1'b0;
        checkOutput("wrap-pushes", 32'(pushCnt[2] - p0), 32'd20);
        checkOutput("wrap-pops", 32'(popCnt[2] - q0), 32'd20);
        nextCycle();

        // ---------------- simultaneous push and pop on a full ch1 ----------------
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b1, 32'h100 + 32'(i));
            nextCycle();
        end
        applyStimulus(1, 1'b1, 32'h104);
        repeat (2) nextCycle();
        p0 = pushCnt[1];
        q0 = popCnt[1];
        checkOutput("sim-ready-full", 32'(srcReady[1]), 32'd0);
        checkOutput("sim-valid-full", 32'(dstValid[1]), 32'd1);
        dstReady[1] = 1'b1;
        nextCycle();
        dstReady[1] = 1'b0;
        checkOutput("sim-push-rejected", 32'(pushCnt[1] - p0), 32'd0);
        checkOutput("sim-pop-honoured", 32'(popCnt[1] - q0), 32'd1);
        checkOutput("sim-ready-t1", 32'(srcReady[1]), 32'd0);
        nextCycle();
        checkOutput("sim-ready-t2", 32'(srcReady[1]), 32'd1);
        nextCycle();
        checkOutput("sim-push-on-rise", 32'(pushCnt[1] - p0), 32'd1);
        checkOutput("sim-refull", 32'(srcReady[1]), 32'd0);
        applyStimulus(1, 1'b0, 32'h0);
        dstReady[1] = 1'b1;
        cyc = 0;
        while ((popCnt[1] - q0) < 5 && cyc < 100) begin
            nextCycle();
            cyc++;
        end
        dstReady[1] = 1'b0;
        checkOutput("sim-drained", 32'(popCnt[1] - q0), 32'd5);
        nextCycle();

        // ---------------- reset with two entries buffered on ch3 ----------------
        applyStimulus(3, 1'b1, 32'h300);
        nextCycle();
        applyStimulus(3, 1'b1, 32'h301);
        nextCycle();
        applyStimulus(3, 1'b0, 32'h0);
        repeat (3) nextCycle();
        checkOutput("rst2-valid-before", 32'(dstValid[3]), 32'd1);
        rstN = 1'b0;
        nextCycle();
        checkOutput("rst2-valid-after", 32'(dstValid[3]), 32'd0);
        checkOutput("rst2-ready-after", 32'(srcReady[3]), 32'd1);
        checkOutput("rst2-data-after", dstData[3*DW +: DW], 32'h0);
        rstN = 1'b1;
        nextCycle();
        checkOutput("rst2-valid-next", 32'(dstValid[3]), 32'd0);

        // ---------------- rate ratio: dst tick every 3rd cycle ----------------
        for (int c = 0; c < NCH; c++) begin
            sent[c] = 0;
            base[c] = popCnt[c];
        end
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 5000) begin
            for (int c = 0; c < NCH; c++)
                if (!srcValid[c] && sent[c] < 100) applyStimulus(c, 1'b1, $urandom);
            dstEn    = (cyc % 3) == 0;
            dstReady = NCH'($urandom);
            for (int c = 0; c < NCH; c++) accV[c] = srcEn && srcValid[c] && srcReady[c];
            nextCycle();
            cyc++;
            for (int c = 0; c < NCH; c++)
                if (accV[c]) begin
                    sent[c]++;
                    srcValid[c] = 1'b0;
                end
            done = 1'b1;
            for (int c = 0; c < NCH; c++)
                if ((popCnt[c] - base[c]) < 100) done = 1'b0;
        end
        dstEn    = 1'b1;
        dstReady = '0;
        for (int c = 0; c < NCH; c++) begin
            checkOutput($sformatf("rate-pops ch%0d", c), 32'(popCnt[c] - base[c]), 32'd100);
            checkOutput($sformatf("rate-leftover ch%0d", c), 32'(expQ[c].size()), 32'd0);
        end
        nextCycle();

        // ---------------- PassData off: handshake counting on dutB ----------------
        bp0       = bPushCnt;
        bq0       = bPopCnt;
        bSent     = 0;
        bSrcValid = 1'b1;
        cyc       = 0;
        while ((bPopCnt - bq0) < 50 && cyc < 2000) begin
            bDstReady = 1'($urandom);
            acc = srcEn && bSrcValid && bSrcReady;
            nextCycle();
            cyc++;
            if (acc) begin
                bSent++;
                if (bSent >= 50) bSrcValid = 1'b0;
            end
        end
        bDstReady = 1'b0;
        repeat (4) nextCycle();
        checkOutput("b-pushes", 32'(bPushCnt - bp0), 32'd50);
        checkOutput("b-pops", 32'(bPopCnt - bq0), 32'd50);
        checkOutput("b-data-idle", 32'(bDstData), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
